// File: rtl/vtl_raster_timing.sv
`default_nettype none
// ============================================================================
// Module  : vtl_raster_timing
// Brief   : Raster timing generator producing sync/blank/border/active flags,
//           active-area coordinates, fetch strobes, a line interrupt and a
//           divided CPU clock.
// Revision: 1.0 - initial release
// ============================================================================
module vtl_raster_timing #(
  parameter int HSW     = 67,
  parameter int HBP     = 71,
  parameter int HLB     = 64,
  parameter int HACT    = 640,
  parameter int HRB     = 94,
  parameter int HFP     = 10,
  parameter int VSW     = 2,
  parameter int VTB     = 68,
  parameter int VACT    = 192,
  parameter int VTOT    = 312,
  parameter int CPU_DIV = 4
) (
  input  logic       F14M,
  input  logic       reset,
  input  logic [1:0] fetch_sel,
  input  logic [5:0] fetch_lead,
  input  logic [9:0] irq_line,
  input  logic       irq_en,
  input  logic       irq_ack,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       border,
  output logic       active,
  output logic [9:0] xcnt,
  output logic [9:0] ycnt,
  output logic       line_start,
  output logic       fetch_stb,
  output logic       frame_start,
  output logic       irq,
  output logic       CPUCK
);

  localparam int CW   = 11;
  localparam int DW   = 8;
  localparam int HTOT = HSW + HBP + HLB + HACT + HRB + HFP;

  localparam logic [CW-1:0] c_one        = CW'(1);
  localparam logic [CW-1:0] c_htot_m1    = CW'(HTOT - 1);
  localparam logic [CW-1:0] c_vtot_m1    = CW'(VTOT - 1);
  localparam logic [CW-1:0] c_vtot       = CW'(VTOT);
  localparam logic [CW-1:0] c_hsw        = CW'(HSW);
  localparam logic [CW-1:0] c_hblank_end = CW'(HSW + HBP);
  localparam logic [CW-1:0] c_hact_st    = CW'(HSW + HBP + HLB);
  localparam logic [CW-1:0] c_hact_end   = CW'(HSW + HBP + HLB + HACT);
  localparam logic [CW-1:0] c_hblank_st  = CW'(HSW + HBP + HLB + HACT + HRB);
  localparam logic [CW-1:0] c_vsw        = CW'(VSW);
  localparam logic [CW-1:0] c_vtb        = CW'(VTB);
  localparam logic [CW-1:0] c_vact_end   = CW'(VTB + VACT);
  localparam logic [9:0]    c_xoff       = 10'(HSW + HBP + HLB);
  localparam logic [9:0]    c_yoff       = 10'(VTB);
  localparam logic [DW-1:0] c_div_one    = DW'(1);
  localparam logic [DW-1:0] c_div_half_m1 = DW'(CPU_DIV / 2 - 1);

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [1:0]    sel_q;
  logic [5:0]    lead_q;
  logic [DW-1:0] div_q;
  logic          cpuck_q;
  logic          hsync_q, vsync_q, blank_q, border_q, active_q;
  logic [9:0]    xcnt_q, ycnt_q;
  logic          line_start_q, fetch_stb_q, frame_start_q, irq_q;

  logic          w_line0;
  logic [1:0]    w_sel;
  logic [5:0]    w_lead;
  logic [CW-1:0] w_lead_ext;
  logic [CW-1:0] w_ls_pos;
  logic [9:0]    w_x, w_y;
  logic          w_hact, w_vact, w_active, w_blank;
  logic          w_fetch_hit;
  logic          w_irq_set;

  always_comb begin
    hcnt_d = hcnt_q + c_one;
    vcnt_d = vcnt_q;
    if (hcnt_q == c_htot_m1) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == c_vtot_m1) ? '0 : vcnt_q + c_one;
    end
  end

  // Line settings latch at hcnt=0, but that same clock already uses the new value.
  assign w_line0    = (hcnt_q == '0);
  assign w_sel      = w_line0 ? fetch_sel  : sel_q;
  assign w_lead     = w_line0 ? fetch_lead : lead_q;
  assign w_lead_ext = {{(CW-6){1'b0}}, w_lead};
  assign w_ls_pos   = (w_lead_ext > c_hact_st) ? '0 : c_hact_st - w_lead_ext;

  assign w_x      = hcnt_q[9:0] - c_xoff;
  assign w_y      = vcnt_q[9:0] - c_yoff;
  assign w_hact   = (hcnt_q >= c_hact_st) && (hcnt_q < c_hact_end);
  assign w_vact   = (vcnt_q >= c_vtb) && (vcnt_q < c_vact_end);
  assign w_active = w_hact && w_vact;
  assign w_blank  = (hcnt_q < c_hblank_end) || (hcnt_q >= c_hblank_st) ||
                    (vcnt_q < c_vsw);

  always_comb begin
    w_fetch_hit = &w_x[2:0];
    case (w_sel)
      2'd1:    w_fetch_hit = &w_x[3:0];
      2'd2:    w_fetch_hit = &w_x[4:0];
      default: w_fetch_hit = &w_x[2:0];
    endcase
  end

  assign w_irq_set = irq_en && w_line0 && (vcnt_q == {1'b0, irq_line}) &&
                     ({1'b0, irq_line} < c_vtot);

  always_ff @(posedge F14M) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      sel_q         <= '0;
      lead_q        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      blank_q       <= 1'b1;
      border_q      <= 1'b0;
      active_q      <= 1'b0;
      xcnt_q        <= '0;
      ycnt_q        <= '0;
      line_start_q  <= 1'b0;
      fetch_stb_q   <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
      div_q         <= '0;
      cpuck_q       <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (w_line0) begin
        sel_q  <= fetch_sel;
        lead_q <= fetch_lead;
      end

      hsync_q       <= (hcnt_q >= c_hsw);
      vsync_q       <= (vcnt_q >= c_vsw);
      blank_q       <= w_blank;
      border_q      <= !w_blank && !w_active;
      active_q      <= w_active;
      xcnt_q        <= w_x;
      ycnt_q        <= w_y;
      line_start_q  <= (hcnt_q == w_ls_pos);
      fetch_stb_q   <= w_hact && w_fetch_hit;
      frame_start_q <= w_line0 && (vcnt_q == '0);

      // Disable dominates, then set beats a coincident acknowledge.
      if (!irq_en)
        irq_q <= 1'b0;
      else if (w_irq_set)
        irq_q <= 1'b1;
      else if (irq_ack)
        irq_q <= 1'b0;

      if (div_q == c_div_half_m1) begin
        div_q   <= '0;
        cpuck_q <= ~cpuck_q;
      end else begin
        div_q <= div_q + c_div_one;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign border      = border_q;
  assign active      = active_q;
  assign xcnt        = xcnt_q;
  assign ycnt        = ycnt_q;
  assign line_start  = line_start_q;
  assign fetch_stb   = fetch_stb_q;
  assign frame_start = frame_start_q;
  assign irq         = irq_q;
  assign CPUCK       = cpuck_q;

endmodule
`default_nettype wire

// File: tb/tb_vtl_raster_timing.sv
`default_nettype none
// ============================================================================
// Module  : tb_vtl_raster_timing
// Brief   : Directed self-checking bench for vtl_raster_timing, using the
//           default horizontal timing and a shortened 8-line frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vtl_raster_timing;

  localparam int HTOT  = 946;
  localparam int VTOT  = 8;
  localparam int FRAME = HTOT * VTOT;

  logic       F14M = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] fetch_sel = 2'd0;
  logic [5:0] fetch_lead = 6'd8;
  logic [9:0] irq_line = 10'd5;
  logic       irq_en = 1'b1;
  logic       irq_ack = 1'b0;

  logic hsync, vsync, blank, border, active, line_start, fetch_stb, frame_start, irq, CPUCK;
  logic [9:0] xcnt, ycnt;
  logic hsync6, vsync6, blank6, border6, active6, line_start6, fetch_stb6, frame_start6, irq6, CPUCK6;
  logic [9:0] xcnt6, ycnt6;
  logic [9:0] ovec, ovec6;

  assign ovec  = {hsync, vsync, blank, border, active, line_start, fetch_stb, frame_start, CPUCK, irq};
  assign ovec6 = {hsync6, vsync6, blank6, border6, active6, line_start6, fetch_stb6, frame_start6, CPUCK6, irq6};

  vtl_raster_timing #(.VTB(4), .VACT(3), .VTOT(VTOT)) u_dut (
    .F14M(F14M), .reset(reset), .fetch_sel(fetch_sel), .fetch_lead(fetch_lead),
    .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack),
    .hsync(hsync), .vsync(vsync), .blank(blank), .border(border), .active(active),
    .xcnt(xcnt), .ycnt(ycnt), .line_start(line_start), .fetch_stb(fetch_stb),
    .frame_start(frame_start), .irq(irq), .CPUCK(CPUCK)
  );

  vtl_raster_timing #(.VTB(4), .VACT(3), .VTOT(VTOT), .CPU_DIV(6)) u_dut6 (
    .F14M(F14M), .reset(reset), .fetch_sel(fetch_sel), .fetch_lead(fetch_lead),
    .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack),
    .hsync(hsync6), .vsync(vsync6), .blank(blank6), .border(border6), .active(active6),
    .xcnt(xcnt6), .ycnt(ycnt6), .line_start(line_start6), .fetch_stb(fetch_stb6),
    .frame_start(frame_start6), .irq(irq6), .CPUCK(CPUCK6)
  );

  always #5 F14M = ~F14M;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pos is the raster index reflected by the outputs seen at this falling edge.
  task automatic tick();
    @(negedge F14M);
    pos++;
  endtask

  task automatic goto(input int target);
    while (pos < target) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_hs, c_vs, c_act, c_ls, c_fs, c_fe, c_irq;
    int first_act, ls_pos, irq_rise, fe_first, fs_first;
    logic [9:0] fx, fy, fe_x, x0, y0;
    logic [3:0] bchk;
    logic bord_b;
    int r1[2], r6[2];
    int n1, n6;
    logic p1, p6;

    repeat (3) @(negedge F14M);
    check_val("reset_outputs", 32'(ovec), 32'(10'b0010000000));
    check_val("reset_outputs_div6", 32'(ovec6), 32'(10'b0010000000));
    reset = 1'b0;
    pos = -1;

    // Frame 1: full scan with fetch_sel=0, fetch_lead=8, irq_line=5
    c_hs = 0; c_vs = 0; c_act = 0; c_ls = 0; c_fs = 0; c_fe = 0;
    first_act = -1; ls_pos = -1; irq_rise = -1; fe_first = -1; fs_first = -1;
    fx = '0; fy = '0; fe_x = '0; x0 = '0; y0 = '0; bchk = '0; bord_b = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      tick();
      if (!hsync) c_hs++;
      if (!vsync) c_vs++;
      if (active) c_act++;
      if (line_start) c_ls++;
      if (fetch_stb) c_fe++;
      if (frame_start) begin
        c_fs++;
        if (fs_first < 0) fs_first = pos;
      end
      if (active && first_act < 0) begin first_act = pos; fx = xcnt; fy = ycnt; end
      if (line_start && ls_pos < 0) ls_pos = pos;
      if (irq && irq_rise < 0) irq_rise = pos;
      if (fetch_stb && fe_first < 0) begin fe_first = pos; fe_x = xcnt; end
      if (pos == 0) begin x0 = xcnt; y0 = ycnt; end
      if (pos == 4*HTOT + 201) bord_b = border;
      if (pos == 2*HTOT + 137) bchk[3] = blank;
      if (pos == 2*HTOT + 138) bchk[2] = blank;
      if (pos == 2*HTOT + 935) bchk[1] = blank;
      if (pos == 2*HTOT + 936) bchk[0] = blank;
    end
    check_val("hsync_low_clocks", 32'(c_hs), 32'(67*8));
    check_val("vsync_low_clocks", 32'(c_vs), 32'(2*946));
    check_val("active_pixels", 32'(c_act), 32'(640*3));
    check_val("line_start_count", 32'(c_ls), 32'd8);
    check_val("frame_start_count", 32'(c_fs), 32'd1);
    check_val("frame_start_pos", 32'(fs_first), 32'd0);
    check_val("fetch_count_sel0", 32'(c_fe), 32'(80*8));
    check_val("first_active_pos", 32'(first_act), 32'(4*946 + 202));
    check_val("first_active_x", 32'(fx), 32'd0);
    check_val("first_active_y", 32'(fy), 32'd0);
    check_val("border_h201", 32'(bord_b), 32'd1);
    check_val("blank_edges", 32'(bchk), 32'(4'b1001));
    check_val("xcnt_at_origin", 32'(x0), 32'd822);
    check_val("ycnt_at_origin", 32'(y0), 32'd1020);
    check_val("line_start_lead8", 32'(ls_pos), 32'd194);
    check_val("first_fetch_pos", 32'(fe_first), 32'd209);
    check_val("first_fetch_x", 32'(fe_x), 32'd7);
    check_val("irq_rise_pos", 32'(irq_rise), 32'(5*946));

    tick();
    check_val("frame_start_period", 32'(frame_start), 32'd1);

    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_val("irq_ack_clear", 32'(irq), 32'd0);

    // Mid-line change of fetch settings: this line keeps sel 0
    goto(FRAME + 500);
    fetch_sel  = 2'd2;
    fetch_lead = 6'd63;
    c_fe = fetch_stb ? 1 : 0;
    while (pos < FRAME + HTOT - 1) begin
      tick();
      if (fetch_stb) c_fe++;
    end
    check_val("fetch_rest_of_line_sel0", 32'(c_fe), 32'd43);

    c_fe = 0; ls_pos = -1; fe_first = -1;
    for (int p = 0; p < HTOT; p++) begin
      tick();
      if (fetch_stb) begin
        c_fe++;
        if (fe_first < 0) fe_first = pos - (FRAME + HTOT);
      end
      if (line_start && ls_pos < 0) ls_pos = pos - (FRAME + HTOT);
    end
    check_val("fetch_count_sel2", 32'(c_fe), 32'd20);
    check_val("first_fetch_h_sel2", 32'(fe_first), 32'd233);
    check_val("line_start_lead63", 32'(ls_pos), 32'd139);

    // Acknowledge coincident with set: set wins
    goto(FRAME + 5*HTOT - 1);
    check_val("irq_before_set", 32'(irq), 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_val("irq_set_beats_ack", 32'(irq), 32'd1);
    tick();
    check_val("irq_held", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_val("irq_ack_clear2", 32'(irq), 32'd0);

    // Disabling clears a pending request
    goto(2*FRAME + 5*HTOT);
    check_val("irq_frame3", 32'(irq), 32'd1);
    irq_en = 1'b0;
    tick();
    check_val("irq_en_clear", 32'(irq), 32'd0);
    irq_en = 1'b1;
    irq_line = 10'd400;
    tick();
    check_val("irq_stays_clear", 32'(irq), 32'd0);

    c_irq = 0;
    while (pos < 4*FRAME - 1) begin
      tick();
      if (irq) c_irq++;
    end
    check_val("irq_line_out_of_range", 32'(c_irq), 32'd0);

    // Reset mid-frame on line 6
    goto(4*FRAME + 6*HTOT + 300);
    check_val("ycnt_line6", 32'(ycnt), 32'd2);
    reset = 1'b1;
    tick();
    check_val("midframe_reset_outputs", 32'(ovec), 32'(10'b0010000000));
    check_val("midframe_reset_xcnt", 32'(xcnt), 32'd0);
    check_val("midframe_reset_outputs_div6", 32'(ovec6), 32'(10'b0010000000));
    tick();
    reset = 1'b0;
    pos = -1;
    tick();
    check_val("frame_start_after_reset", 32'(frame_start), 32'd1);
    check_val("vsync_after_reset", 32'(vsync), 32'd0);
    tick();
    check_val("frame_start_one_clock", 32'(frame_start), 32'd0);

    // CPU clock period from successive rising edges
    n1 = 0; n6 = 0; r1[0] = 0; r1[1] = 0; r6[0] = 0; r6[1] = 0;
    p1 = CPUCK; p6 = CPUCK6;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (CPUCK && !p1 && n1 < 2) begin r1[n1] = pos; n1++; end
      if (CPUCK6 && !p6 && n6 < 2) begin r6[n6] = pos; n6++; end
      p1 = CPUCK;
      p6 = CPUCK6;
    end
    check_val("cpuck_period_div4", 32'(r1[1] - r1[0]), 32'd4);
    check_val("cpuck_period_div6", 32'(r6[1] - r6[0]), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vtl_raster_timing.md
VTL_RASTER_TIMING -- requirements
Module: vtl_raster_timing

Interface
REQ-001 SHALL provide parameter HSW, default 67, hsync width in pixel clocks.
REQ-002 SHALL provide parameter HBP, default 71, horizontal back porch in pixel clocks.
REQ-003 SHALL provide parameter HLB, default 64, left border width.
REQ-004 SHALL provide parameter HACT, default 640, active width.
REQ-005 SHALL provide parameter HRB, default 94, right border width.
REQ-006 SHALL provide parameter HFP, default 10, horizontal front porch.
REQ-007 SHALL provide parameter VSW, default 2, vsync lines.
REQ-008 SHALL provide parameter VTB, default 68, top border lines, counted from line 0 and including the VSW lines.
REQ-009 SHALL provide parameter VACT, default 192, active lines.
REQ-010 SHALL provide parameter VTOT, default 312, total lines.
REQ-011 SHALL provide parameter CPU_DIV, default 4, CPU clock divide ratio; must be even and at least 2.
REQ-012 SHALL have port F14M, input, 1 bit, pixel clock.
REQ-013 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-014 SHALL have port fetch_sel, input, 2 bits, fetch period: 0 = 8 px, 1 = 16 px, 2 = 32 px, 3 = 8 px.
REQ-015 SHALL have port fetch_lead, input, 6 bits, number of pixel clocks before active x=0 at which the line-start strobe fires.
REQ-016 SHALL have port irq_line, input, 10 bits, raster line that raises the interrupt.
REQ-017 SHALL have port irq_en, input, 1 bit, interrupt enable.
REQ-018 SHALL have port irq_ack, input, 1 bit, interrupt acknowledge pulse.
REQ-019 SHALL have port hsync, output, 1 bit, active-low horizontal sync.
REQ-020 SHALL have port vsync, output, 1 bit, active-low vertical sync.
REQ-021 SHALL have port blank, output, 1 bit, high in porch and sync areas.
REQ-022 SHALL have port border, output, 1 bit, high in the visible non-active area.
REQ-023 SHALL have port active, output, 1 bit, high in the active area.
REQ-024 SHALL have port xcnt, output, 10 bits, active-area x (hcnt - (HSW+HBP+HLB)), wrapping mod 1024.
REQ-025 SHALL have port ycnt, output, 10 bits, active-area y (vcnt - VTB), wrapping mod 1024.
REQ-026 SHALL have port line_start, output, 1 bit, one-clock row-address load strobe.
REQ-027 SHALL have port fetch_stb, output, 1 bit, one-clock RAM address-advance strobe.
REQ-028 SHALL have port frame_start, output, 1 bit, one-clock pulse at hcnt=0, vcnt=0.
REQ-029 SHALL have port irq, output, 1 bit, level interrupt request.
REQ-030 SHALL have port CPUCK, output, 1 bit, F14M divided by CPU_DIV, 50 % duty.

Function
REQ-031 SHALL count hcnt from 0 to HTOT-1, where HTOT = HSW+HBP+HLB+HACT+HRB+HFP (default 946), and vcnt from 0 to VTOT-1, incrementing vcnt when hcnt wraps.
REQ-032 SHALL register all outputs; outputs reflect the current hcnt/vcnt with exactly 1 clock latency.
REQ-033 SHALL drive hsync=0 while hcnt<HSW, and vsync=0 while vcnt<VSW.
REQ-034 SHALL drive blank=1 while hcnt<HSW+HBP, or hcnt>=HSW+HBP+HLB+HACT+HRB, or vcnt<VSW.
REQ-035 SHALL drive active=1 only when hcnt is in [HSW+HBP+HLB, +HACT) and vcnt is in [VTB, VTB+VACT).
REQ-036 SHALL drive border = !blank && !active.
REQ-037 SHALL assert line_start for exactly one clock at hcnt = HSW+HBP+HLB-fetch_lead, on every line; a fetch_lead larger than HSW+HBP+HLB saturates to hcnt=0.
REQ-038 SHALL assert fetch_stb when xcnt[2:0]=7, xcnt[3:0]=15, or xcnt[4:0]=31 per fetch_sel, and only while the horizontal position is inside the active width.
REQ-039 SHALL sample fetch_sel and fetch_lead only at hcnt=0; mid-line changes take effect from the next line.
REQ-040 SHALL set irq=1 at the hcnt=0 of line vcnt==irq_line when irq_en=1.
REQ-041 SHALL clear irq on irq_ack.
REQ-042 SHALL give set priority when a set and an irq_ack fall on the same clock.
REQ-043 SHALL clear irq immediately, and suppress new sets, while irq_en=0.
REQ-044 SHALL never set irq when irq_line>=VTOT.
REQ-045 SHALL toggle CPUCK every CPU_DIV/2 clocks, free-running and independent of raster position.

Reset
REQ-046 SHALL, on reset=1 at a rising F14M edge, clear hcnt, vcnt, the CPU divider and irq to 0.
REQ-047 SHALL hold these reset output values: hsync=0, vsync=0, blank=1, border=0, active=0, line_start=0, fetch_stb=0, frame_start=0, CPUCK=0.
REQ-048 SHALL, on reset mid-frame, restart at hcnt=0, vcnt=0; frame_start asserts 1 clock after reset deasserts.

Verification
REQ-049 SHALL verify defaults: with reset released, hsync low for 67 clocks per 946, vsync low for 2 lines per 312, frame_start every 295152 clocks.
REQ-050 SHALL verify the active window: active first high at hcnt=202, vcnt=68 with xcnt=0 and ycnt=0; 640x192 active pixels per frame; border asserted at hcnt=201.
REQ-051 SHALL verify fetch: fetch_sel=0 gives 80 fetch_stb per active line at xcnt=7,15,...; fetch_sel=2 gives 20 per line; fetch_sel changed mid-line applies from the next line only.
REQ-052 SHALL verify line_start: fetch_lead=8 gives a pulse at hcnt=194; fetch_lead=63 gives a pulse at hcnt=139.
REQ-053 SHALL verify interrupts: irq_line=100 with irq_en=1 raises irq at vcnt=100, hcnt=0 (+1); irq_ack clears it; ack coincident with set leaves irq=1; irq_line=400 never fires.
REQ-054 SHALL verify reset and CPU clock: reset asserted at vcnt=150 returns all outputs to reset values next clock; CPUCK period is 4 clocks, and 6 clocks with CPU_DIV=6.
